div_unit: RTL

Multi-cycle integer divide/remainder unit for the RV32 multi-cycle core; the sequential, handshaked counterpart to the single-cycle combinational ALU. It executes DIV, DIVU, REM and REMU on operands already prepared by the datapath (rs1, rs2). It returns one 32-bit result per request. The control FSM holds the instruction in its execute state until `done_o` pulses.

---
 rtl/div_unit_pkg.sv | 35 +++
 rtl/div_unit_step.sv | 34 +++
 rtl/div_unit.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/div_unit_pkg.sv
// Shared RV32 execute-stage types.
//   ALU_Ops : single-cycle ALU operation select
//   Div_Ops : multi-cycle divide/remainder operation select (2-bit encoding)
// Helpers classify divide ops as signed and as remainder-returning.
package div_unit_pkg;

  typedef enum logic [3:0] {
    AluAdd  = 4'd0,
    AluSub  = 4'd1,
    AluAnd  = 4'd2,
    AluOr   = 4'd3,
    AluXor  = 4'd4,
    AluSll  = 4'd5,
    AluSrl  = 4'd6,
    AluSra  = 4'd7,
    AluSlt  = 4'd8,
    AluSltu = 4'd9
  } ALU_Ops;

  typedef enum logic [1:0] {
    DivOp  = 2'd0,
    DivuOp = 2'd1,
    RemOp  = 2'd2,
    RemuOp = 2'd3
  } Div_Ops;

  function automatic logic is_signed_op(Div_Ops op);
    return (op == DivOp) || (op == RemOp);
  endfunction

  function automatic logic is_rem_op(Div_Ops op);
    return (op == RemOp) || (op == RemuOp);
  endfunction

endpackage

// File: rtl/div_unit_step.sv
// One restoring-division step (combinational).
//   rem_in/quo_in : partial remainder (W+1 bits) and quotient/dividend shift register
//   dvsr          : divisor magnitude
//   rem_out/quo_out : state after shifting {rem, quo} left and a trial subtract
module div_unit_step #(
  parameter int W = 32
) (
  input  logic [W:0]   rem_in,
  input  logic [W-1:0] quo_in,
  input  logic [W-1:0] dvsr,
  output logic [W:0]   rem_out,
  output logic [W-1:0] quo_out
);

  logic [W:0]   shifted;
  logic [W+1:0] trial;

  // The partial remainder never exceeds the divisor, so its top bit is
  // always clear and the shifted value still fits in W+1 bits.
  // The subtract runs one bit wider than the operands so that its sign
  // bit is a true borrow.
  always_comb begin
    shifted = {W'(rem_in), quo_in[W-1]};
    trial   = {1'b0, shifted} - {2'b00, dvsr};
    if (!trial[W+1]) begin
      rem_out = trial[W:0];
      quo_out = {quo_in[W-2:0], 1'b1};
    end else begin
      rem_out = shifted;
      quo_out = {quo_in[W-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/div_unit.sv
// Multi-cycle restoring divide/remainder unit (DIV, DIVU, REM, REMU).
//   clk_i, reset_ni : clock, async active-low reset
//   start_i, op_i, a_i, b_i : request, sampled only in Idle
//   busy_o : high while not Idle
//   done_o : one-cycle pulse, y_o valid alongside
//   y_o    : result, held until the next accepted request completes
// Normal ops take 34 cycles; divide-by-zero and signed overflow take 1.
import div_unit_pkg::*;

module div_unit #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  reset_ni,
  input  logic                  start_i,
  input  Div_Ops                op_i,
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [DATA_WIDTH-1:0] y_o
);

  localparam int W = DATA_WIDTH;

  typedef enum logic [2:0] {Idle, Prep, Iterate, Fixup, Done} state_t;

  state_t       state, state_nxt;
  Div_Ops       op_q;
  logic [W:0]   rem_q;
  logic [W-1:0] quo_q, dvsr_q, y_q;
  logic         neg_quo_q, neg_rem_q;
  logic [5:0]   cnt_q;
  logic         busy_q, done_q;

  logic         special;
  logic [W-1:0] special_y;
  logic [W-1:0] a_mag, b_mag;
  logic [W:0]   step_rem_in, step_rem;
  logic [W-1:0] step_quo_in, step_dvsr, step_quo;
  logic [W-1:0] quo_fix, rem_fix, y_fix;

  // Corner cases resolved at accept. The overflow result equals the
  // dividend itself (most negative value), so a_i is reused for it.
  always_comb begin
    special   = 1'b0;
    special_y = '0;
    if (b_i == '0) begin
      special   = 1'b1;
      special_y = is_rem_op(op_i) ? a_i : '1;
    end else if (is_signed_op(op_i) && (a_i == {1'b1, {(W-1){1'b0}}}) && (b_i == '1)) begin
      special   = 1'b1;
      special_y = is_rem_op(op_i) ? '0 : a_i;
    end
  end

  // In Prep the registers still hold the raw operands; the first step is
  // taken on their magnitudes so that 32 steps finish by the Fixup edge.
  always_comb begin
    a_mag = (is_signed_op(op_q) && quo_q[W-1])  ? -quo_q  : quo_q;
    b_mag = (is_signed_op(op_q) && dvsr_q[W-1]) ? -dvsr_q : dvsr_q;
    if (state == Prep) begin
      step_rem_in = '0;
      step_quo_in = a_mag;
      step_dvsr   = b_mag;
    end else begin
      step_rem_in = rem_q;
      step_quo_in = quo_q;
      step_dvsr   = dvsr_q;
    end
  end

  div_unit_step #(.W(W)) u_div_step (
    .rem_in  (step_rem_in),
    .quo_in  (step_quo_in),
    .dvsr    (step_dvsr),
    .rem_out (step_rem),
    .quo_out (step_quo)
  );

  always_comb begin
    quo_fix = neg_quo_q ? -quo_q : quo_q;
    rem_fix = W'(neg_rem_q ? -rem_q : rem_q);
    y_fix   = is_rem_op(op_q) ? rem_fix : quo_fix;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      Idle:    if (start_i) state_nxt = special ? Done : Prep;
      Prep:    state_nxt = Iterate;
      Iterate: if (cnt_q == 6'(W-1)) state_nxt = Fixup;
      Fixup:   state_nxt = Done;
      Done:    state_nxt = Idle;
      default: state_nxt = Idle;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state  <= Idle;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      busy_q <= (state_nxt != Idle);
      done_q <= (state_nxt == Done);
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      op_q      <= DivOp;
      rem_q     <= '0;
      quo_q     <= '0;
      dvsr_q    <= '0;
      y_q       <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      case (state)
        Idle: if (start_i) begin
          op_q   <= op_i;
          quo_q  <= a_i;
          dvsr_q <= b_i;
          rem_q  <= '0;
          cnt_q  <= '0;
          if (special) y_q <= special_y;
        end
        Prep: begin
          neg_quo_q <= is_signed_op(op_q) & (quo_q[W-1] ^ dvsr_q[W-1]);
          neg_rem_q <= is_signed_op(op_q) & quo_q[W-1];
          dvsr_q    <= b_mag;
          rem_q     <= step_rem;
          quo_q     <= step_quo;
          cnt_q     <= 6'd1;
        end
        Iterate: begin
          rem_q <= step_rem;
          quo_q <= step_quo;
          cnt_q <= cnt_q + 6'd1;
        end
        Fixup: y_q <= y_fix;
        default: ;
      endcase
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign y_o    = y_q;

endmodule
